// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arbitrating multiplexer.
package arb_mux_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational arbiter: round-robin after the pointer, or fixed lowest-index priority.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int SELECT_BITS = sel_bits(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0]  req,
  input  logic [SELECT_BITS-1:0] last,
  input  arb_mode_e              mode,
  output logic [NUM_INPUTS-1:0]  grant_onehot,
  output logic [SELECT_BITS-1:0] grant,
  output logic                   grant_valid
);

  int                   cand;
  logic [SELECT_BITS-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = 0;
    idx         = '0;
    if (mode == ARB_FIXED) begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        if (req[k]) begin
          grant       = SELECT_BITS'(k);
          grant_valid = 1'b1;
        end
      end
    end else begin
      // Scan backwards so the earliest position after the pointer wins; wrap is mod NUM_INPUTS.
      for (int i = NUM_INPUTS; i >= 1; i--) begin
        cand = int'(last) + i;
        if (cand >= NUM_INPUTS) cand = cand - NUM_INPUTS;
        idx = SELECT_BITS'(cand);
        if (req[idx]) begin
          grant       = idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_onehot
    assign grant_onehot[gi] = grant_valid && (grant == SELECT_BITS'(gi));
  end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 handshaked arbitrating mux with a single registered output stage.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int NUM_INPUTS  = 4,
  parameter  int DATA_WIDTH  = 32,
  localparam int SELECT_BITS = sel_bits(NUM_INPUTS)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus,
  input  logic [NUM_INPUTS-1:0]            i_valid,
  output logic [NUM_INPUTS-1:0]            o_ready,
  input  logic                             i_fixed_prio,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic [SELECT_BITS-1:0]           o_sel,
  output logic                             o_valid,
  input  logic                             i_ready
);

  logic [DATA_WIDTH-1:0]  chan_data [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  grant_onehot;
  logic [SELECT_BITS-1:0] grant;
  logic                   grant_valid;
  logic                   load;
  logic                   accept;
  arb_mode_e              mode;

  logic [DATA_WIDTH-1:0]  data_reg;
  logic [SELECT_BITS-1:0] sel_reg;
  logic                   valid_reg;
  logic [SELECT_BITS-1:0] last_reg;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
    assign chan_data[gi] = i_data_bus[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign mode = arb_mode_e'(i_fixed_prio);

  rr_arbiter #(
    .NUM_INPUTS  (NUM_INPUTS),
    .SELECT_BITS (SELECT_BITS)
  ) u_arb (
    .req          (i_valid),
    .last         (last_reg),
    .mode         (mode),
    .grant_onehot (grant_onehot),
    .grant        (grant),
    .grant_valid  (grant_valid)
  );

  // The output stage can take a new beat when empty or draining this cycle.
  assign load    = ~valid_reg | i_ready;
  assign o_ready = (load && !i_rst) ? grant_onehot : '0;
  assign accept  = |o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_reg  <= '0;
      sel_reg   <= '0;
      valid_reg <= 1'b0;
      last_reg  <= SELECT_BITS'(NUM_INPUTS - 1);
    end else if (accept) begin
      data_reg  <= chan_data[grant];
      sel_reg   <= grant;
      valid_reg <= 1'b1;
      if (mode == ARB_RR) last_reg <= grant;
    end else if (i_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign o_data  = data_reg;
  assign o_sel   = sel_reg;
  assign o_valid = valid_reg;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux with a reference arbiter model and an output scoreboard.
module tb_arb_mux;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SB = 2;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [N*DW-1:0]   i_data_bus;
  logic [N-1:0]      i_valid;
  logic [N-1:0]      o_ready;
  logic              i_fixed_prio;
  logic [DW-1:0]     o_data;
  logic [SB-1:0]     o_sel;
  logic              o_valid;
  logic              i_ready;

  typedef struct {
    int sel;
    int data;
  } beat_t;

  beat_t q[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    m_ptr;
  bit    m_valid;
  int    last_sel;
  int    last_data;

  arb_mux #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data_bus   (i_data_bus),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_fixed_prio (i_fixed_prio),
    .o_data       (o_data),
    .o_sel        (o_sel),
    .o_valid      (o_valid),
    .i_ready      (i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input bit fixed, input int ptr);
    if (fixed) begin
      for (int k = 0; k < N; k++) if (v[k]) return k;
    end else begin
      for (int i = 1; i <= N; i++) if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    i_rst   = 1'b1;
    i_valid = 4'b1111;
    i_ready = 1'b1;
    #1;
    check("ready_in_reset", {28'd0, o_ready}, 32'd0);
    @(posedge i_clk); #1;
    m_ptr     = N - 1;
    m_valid   = 1'b0;
    last_sel  = 0;
    last_data = 0;
    q.delete();
    $display("reset applied");
  endtask

  task automatic step(input logic [N-1:0] v, input bit fixed, input bit rdy);
    int          g;
    bit          ld;
    logic [N-1:0] exp_ready;
    i_rst        = 1'b0;
    i_valid      = v;
    i_fixed_prio = fixed;
    i_ready      = rdy;
    #1;
    check("o_valid", {31'd0, o_valid}, {31'd0, m_valid});
    if (m_valid) begin
      if (q.size() == 0) check("scoreboard_empty", 32'd0, 32'd1);
      else begin
        check("o_sel", {30'd0, o_sel}, q[0].sel);
        check("o_data", {24'd0, o_data}, q[0].data);
      end
    end else begin
      check("o_sel_hold", {30'd0, o_sel}, last_sel);
      check("o_data_hold", {24'd0, o_data}, last_data);
    end
    g         = model_grant(v, fixed, m_ptr);
    ld        = !m_valid || rdy;
    exp_ready = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
    check("o_ready", {28'd0, o_ready}, {28'd0, exp_ready});
    if (m_valid && rdy && q.size() > 0) void'(q.pop_front());
    if (exp_ready != 4'b0000) begin
      q.push_back('{sel: g, data: 32'hA0 + g});
      last_sel  = g;
      last_data = 32'hA0 + g;
      m_valid   = 1'b1;
      if (!fixed) m_ptr = g;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    $display("step valid=%b fixed=%0d ready=%0d o_ready=%b o_valid=%0d o_sel=%0d o_data=%02h",
             v, fixed, rdy, o_ready, o_valid, o_sel, o_data);
    @(posedge i_clk); #1;
  endtask

  initial begin
    i_data_bus   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    i_fixed_prio = 1'b0;
    i_valid      = '0;
    i_ready      = 1'b1;
    i_rst        = 1'b1;

    do_reset();
    step(4'b0000, 0, 1);                          // reset state of the outputs
    for (int i = 0; i < 8; i++) step(4'b1111, 0, 1);   // round-robin 0..3 twice
    step(4'b0010, 0, 1);                          // pointer to 1
    for (int i = 0; i < 3; i++) step(4'b1010, 0, 1);   // 3,1,3
    for (int i = 0; i < 4; i++) step(4'b1111, 1, 1);   // fixed: always 0
    step(4'b1111, 0, 1);                          // resumes after held pointer 3 -> 0
    step(4'b1111, 0, 1);                          // 1
    step(4'b1111, 0, 1);                          // 2 loads into output
    for (int i = 0; i < 3; i++) step(4'b1111, 0, 0);   // backpressure hold
    step(4'b0100, 0, 1);                          // drain and reload channel 2 together
    step(4'b0000, 0, 1);                          // drain with no request
    step(4'b0000, 0, 1);                          // empty, data held at A2
    step(4'b0010, 0, 1);
    step(4'b1111, 0, 1);
    do_reset();                                   // reset with a beat in flight
    step(4'b1111, 0, 1);                          // first grant is channel 0
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
